dfd_stream_harness: RTL

- Parametrised on-board stimulus/capture harness for generated dfd_N dataflow modules with a req/ack list-output interface.
- A free-running phase timer alternates the DUT between run and idle phases.
- During run, the harness issues repeated req/ack transactions and latches the N returned values when the last value is valid.
- It counts completions, flags timeouts, and summarises status on the board LEDs.
- Sits at top level between board pins and one DUT instance.

---
 rtl/dfd_harness_pkg.sv | 22 ++
 rtl/dfd_phase_timer.sv | 38 +++
 rtl/dfd_stream_harness.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/dfd_harness_pkg.sv
// Shared definitions for the dfd_N stream harness.
//   - Transaction FSM state encodings and the matching typed enum.
//   - Bit positions of the fixed status flags on the board LEDs.
package dfd_harness_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_GAP     = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StReq     = ST_REQ,
        StCapture = ST_CAPTURE,
        StGap     = ST_GAP
    } state_e;

    localparam int unsigned LED_RUN  = 7;
    localparam int unsigned LED_ERR  = 6;
    localparam int unsigned LED_DONE = 5;

endpackage

// File: rtl/dfd_phase_timer.sv
// Free-running phase timer for the dfd_N stream harness.
// The counter wraps every 2^TIMER_W cycles; the cycle it reads zero the run
// flag toggles on the following edge, so run phases and idle phases alternate.
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   synchronous active-high reset (timer=0, run=0)
//   run         out  registered run-phase flag
//   phase_edge  out  high for the one cycle the timer reads zero (run toggles next edge)
module dfd_phase_timer #(
    parameter int unsigned TIMER_W = 25
) (
    input  logic CLOCK_50,
    input  logic reset,
    output logic run,
    output logic phase_edge
);

    localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1);

    logic [TIMER_W-1:0] timer_q;
    logic               run_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            timer_q <= '0;
            run_q   <= 1'b0;
        end else begin
            timer_q <= timer_q + TIMER_ONE;
            if (phase_edge) begin
                run_q <= ~run_q;
            end
        end
    end

    assign phase_edge = (timer_q == '0);
    assign run        = run_q;

endmodule

// File: rtl/dfd_stream_harness.sv
// On-board stimulus/capture harness for a generated dfd_N dataflow module with
// a req/ack list-output interface. During each run phase it issues repeated
// req/ack transactions, latches the N returned values when the last channel is
// valid, counts completions and flags timeouts.
// Optional feature macro: DFD_HARNESS_CHECKSUM_EN adds a running XOR checksum
// of all captured values, exported on `checksum` and shown on LED[4:0].
// Ports:
//   CLOCK_50    in   system clock
//   reset       in   synchronous active-high reset
//   dut_ready   out  run-phase indicator, drives DUT ready
//   dut_req     out  request to DUT
//   dut_done    in   DUT done, reflected on LED only
//   dut_ack     in   DUT acknowledge
//   dut_values  in   value i at bits [i*WIDTH +: WIDTH]
//   dut_valid   in   per-channel valid (only the last channel gates completion)
//   cap_values  out  last captured value set
//   xact_count  out  completed transaction count (wraps)
//   err         out  sticky timeout flag
//   LED         out  {run, err, done, count[4:0] or checksum[4:0]}
//   checksum    out  running XOR checksum (DFD_HARNESS_CHECKSUM_EN only)
module dfd_stream_harness
    import dfd_harness_pkg::*;
#(
    parameter int unsigned N_VALUES   = 3,
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned TIMER_W    = 25,
    parameter int unsigned GAP_CYCLES = 10,
    parameter int unsigned TIMEOUT    = 1024,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    output logic                      dut_ready,
    output logic                      dut_req,
    input  logic                      dut_done,
    input  logic                      dut_ack,
    input  logic [N_VALUES*WIDTH-1:0] dut_values,
    input  logic [N_VALUES-1:0]       dut_valid,
    output logic [N_VALUES*WIDTH-1:0] cap_values,
    output logic [CNT_W-1:0]          xact_count,
    output logic                      err,
    output logic [7:0]                LED
`ifdef DFD_HARNESS_CHECKSUM_EN
    ,
    output logic [WIDTH-1:0]          checksum
`endif
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic run;
    logic phase_edge;
    logic run_next;
    logic handshake;
    logic unused_valid;

    state_e                      state_q;
    logic                        req_q;
    logic [N_VALUES*WIDTH-1:0]   cap_q;
    logic [CNT_W-1:0]            cnt_q;
    logic                        err_q;
    logic [WAIT_W-1:0]           wait_q;
    logic [GAP_W-1:0]            gap_q;

    dfd_phase_timer #(
        .TIMER_W (TIMER_W)
    ) u_phase_timer (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .run        (run),
        .phase_edge (phase_edge)
    );

    // Value dut_ready will hold after this edge; lets the FSM move in step
    // with the phase flip instead of one cycle behind it.
    assign run_next  = run ^ phase_edge;
    assign handshake = dut_ack & dut_valid[N_VALUES-1];

    // Only the last valid bit gates completion; the rest are deliberately ignored.
    assign unused_valid = ^dut_valid;

`ifdef DFD_HARNESS_CHECKSUM_EN
    logic [WIDTH-1:0] chk_q;
    logic [WIDTH-1:0] val_xor;

    always_comb begin
        val_xor = '0;
        for (int i = 0; i < int'(N_VALUES); i++) begin
            val_xor = val_xor ^ dut_values[i*WIDTH +: WIDTH];
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            cap_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            wait_q  <= '0;
            gap_q   <= '0;
`ifdef DFD_HARNESS_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    req_q <= 1'b0;
                    if (run_next) begin
                        state_q <= StReq;
                        wait_q  <= '0;
                    end
                end
                StReq: begin
                    if (handshake) begin
                        // Values and count are registered on the handshake edge so they
                        // are already visible during the CAPTURE cycle.
                        state_q <= StCapture;
                        req_q   <= 1'b0;
                        cap_q   <= dut_values;
                        cnt_q   <= cnt_q + CNT_ONE;
`ifdef DFD_HARNESS_CHECKSUM_EN
                        chk_q   <= chk_q ^ val_xor;
`endif
                    end else if (!run_next) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                    end else if (req_q && (wait_q == WAIT_LAST)) begin
                        state_q <= StGap;
                        gap_q   <= '0;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        req_q <= 1'b1;
                        // Timeout budget counts cycles with req actually asserted.
                        if (req_q) begin
                            wait_q <= wait_q + WAIT_ONE;
                        end
                    end
                end
                StCapture: begin
                    req_q   <= 1'b0;
                    state_q <= StGap;
                    gap_q   <= '0;
                end
                StGap: begin
                    req_q <= 1'b0;
                    if (gap_q == GAP_LAST) begin
                        wait_q  <= '0;
                        state_q <= run_next ? StReq : StIdle;
                    end else begin
                        gap_q <= gap_q + GAP_ONE;
                    end
                end
            endcase
        end
    end

    assign dut_ready  = run;
    assign dut_req    = req_q;
    assign cap_values = cap_q;
    assign xact_count = cnt_q;
    assign err        = err_q;

`ifdef DFD_HARNESS_CHECKSUM_EN
    assign checksum = chk_q;
`endif

    always_comb begin
        LED           = '0;
        LED[LED_RUN]  = run;
        LED[LED_ERR]  = err_q;
        LED[LED_DONE] = dut_done;
`ifdef DFD_HARNESS_CHECKSUM_EN
        LED[4:0]      = 5'(chk_q);
`else
        LED[4:0]      = 5'(cnt_q);
`endif
    end

endmodule
